// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes, FSM
// state encoding, error causes and the latched request record.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_e;

  // Only the parts of the request still needed after accept are kept;
  // the word address lives in the mem_addr register.
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [15:0] wdata;
  } lsu_req_t;

  function automatic logic acc_illegal(input logic store, input logic [2:0] f3);
    if (store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic acc_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b10:   return a != 2'b00;
      2'b01:   return a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and byte/half merge for RMW stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_val = {{24{b[7]}}, b};
      F3_H:    load_val = {{16{h[15]}}, h};
      F3_BU:   load_val = {24'd0, b};
      F3_HU:   load_val = {16'd0, h};
      default: load_val = word;
    endcase

    merged = word;
    case (funct3[1:0])
      2'b00: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (addr_lo[1]) merged[31:16] = wdata;
        else            merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only SRAM: sub-word stores are done
// as read-modify-write, with a per-wait-state timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  logic [2:0]       state_q, state_d;
  lsu_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]      load_data_q, load_data_d, mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      load_val, merged;

  lsu_lane_align u_align (
    .addr_lo  (req_q.addr_lo),
    .funct3   (req_q.funct3),
    .word     (mem_rdata),
    .wdata    (req_q.wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;

    case (state_q)
      // FIN doubles as an idle cycle so back-to-back requests lose nothing.
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (start) begin
          req_d      = '{store: op_store, funct3: op_funct3,
                         addr_lo: op_addr[1:0], wdata: op_wdata[15:0]};
          mem_addr_d = {op_addr[31:2], 2'b00};
          if (acc_illegal(op_store, op_funct3) || acc_misaligned(op_funct3, op_addr[1:0])) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (op_store && op_funct3 == F3_W) begin
            state_d     = ST_WR_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = op_wdata;
            busy_d      = 1'b1;
          end else begin
            state_d   = ST_RD_REQ;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
            busy_d    = 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: begin
        if (mem_ready) begin
          if (req_q.store) begin
            state_d     = ST_WR_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d     = ST_FIN;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            load_data_d = load_val;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR_REQ: begin
        state_d = ST_WR_WAIT;
        cnt_d   = '0;
      end
      ST_WR_WAIT: begin
        if (mem_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          err_d   = !mem_ready;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-wide SRAM peripheral.
- Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into single-word SRAM accesses using the SRAM's req/we/ready handshake.
- The SRAM has no byte enables, so sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data to the core and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for mem_ready after a request before aborting with err.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request from the core; accepted only while busy=0
- op_store  input  1  1=store, 0=load
- op_funct3  input  3  RV32I funct3 (size and unsigned bit)
- op_addr  input  32  byte address
- op_wdata  input  32  store data, right-aligned
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = misaligned, illegal funct3, or timeout
- load_data  output  32  extended load result; valid with done, holds until the next done
- mem_req  output  1  one-cycle SRAM request pulse
- mem_we  output  1  SRAM write enable
- mem_addr  output  32  word address, always {op_addr[31:2],2'b00}
- mem_wdata  output  32  SRAM write word
- mem_rdata  input  32  SRAM read word, valid while mem_ready=1
- mem_ready  input  1  SRAM completion, arrives one cycle after a sampled mem_req

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. FSM goes to IDLE and the timeout counter clears.
- Reset mid-operation abandons the access. No done is issued.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- Accept: start=1 in IDLE latches op_store, op_funct3, op_addr and op_wdata. busy rises next cycle. start while busy=1 is ignored.
- Check on accept:
  - Illegal: loads with funct3 011, 110 or 111; stores with funct3 other than 000, 001 or 010.
  - Misaligned: word with addr[1:0]!=0; half with addr[0]!=0.
  - Either case goes straight to FIN with err=1. No mem_req is issued.
- Loads: RD_REQ → RD_WAIT → FIN.
  - RD_REQ drives mem_req=1, mem_we=0 for exactly one cycle.
  - RD_WAIT: on mem_ready, extract the lane selected by addr[1:0].
  - Byte/half are sign-extended for funct3 000/001 and zero-extended for 100/101.
  - Start to done is 4 cycles: start at c0, mem_req at c1, mem_ready at c2, done at c3.
- SW: WR_REQ → WR_WAIT → FIN. mem_req=1, mem_we=1, mem_wdata=op_wdata. Same 4-cycle latency.
- SB/SH: RD_REQ → RD_WAIT → WR_REQ → WR_WAIT → FIN.
  - In RD_WAIT, on mem_ready, merge op_wdata[7:0] or [15:0] into the read word at the addressed lane. Other bytes are unchanged.
  - Start to done is 6 cycles.
- FIN: done=1 for one cycle and err is valid. busy clears in the same cycle done asserts, so start is accepted again that cycle.
- mem_ready seen outside RD_WAIT/WR_WAIT is ignored.
- Timeout: the counter resets on entering a WAIT state and increments each cycle without mem_ready. At TIMEOUT it goes to FIN with err=1.
  - If the timeout hits during the RMW read, no write is issued.
  - load_data is not updated on any error.
- mem_we and mem_wdata hold their value outside mem_req cycles. mem_addr is stable for the whole operation.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - the state enum
  - the err-cause encoding, for future use
- Sub-module lsu_lane_align: purely combinational.
  - Inputs: addr[1:0], funct3, word.
  - Produces the extended load value and the merged store word.
  - Reused by both the load and RMW paths.

Test Plan:
- Preload SRAM word 0x10 with 0x8899AABB. LB at 0x13 → after 4 cycles done=1, err=0, load_data=0xFFFFFF88. LBU at 0x13 → load_data=0x00000088.
- LH at 0x12, same word → load_data=0xFFFF8899. LW at 0x11 → done, err=1, no mem_req observed, load_data unchanged.
- Word 0x20=0x11223344. SB 0xAB at 0x21 → mem_req sequence read then write, mem_wdata=0x1122AB44, done 6 cycles after start. A following LW at 0x20 returns 0x1122AB44.
- SW 0xDEADBEEF at 0x40 → single write pulse, mem_addr=0x40, done at c3. A start pulsed during busy is ignored, shown by no extra mem_req.
- Stub holds mem_ready=0 after a LW request → done with err=1 exactly TIMEOUT cycles after entering RD_WAIT. The next LW completes normally.
- Assert reset during WR_WAIT of an SH → all outputs 0, no done pulse. After release, an LW completes in 4 cycles.
